riscv_decode_alu: RTL and testbench

RISCV_DECODE_ALU -- requirements
Module: riscv_decode_alu

---
 rtl/riscv_decode_alu_pkg.sv | 36 +++
 rtl/riscv_decode_alu_alu_core.sv | 22 ++
 rtl/riscv_decode_alu.sv | 118 +++++++++++
 tb/tb_riscv_decode_alu.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_decode_alu_pkg.sv
// Shared constants for the RV32I decode/ALU slice: opcodes, instruction classes,
// ALU operation codes and the phase encodings of the external sequencer.
package riscv_decode_alu_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IARITH = 7'b0010011;

    typedef enum logic [2:0] {
        TIPO_R      = 3'd0,
        TIPO_LOAD   = 3'd1,
        TIPO_STORE  = 3'd2,
        TIPO_BRANCH = 3'd3,
        TIPO_IARITH = 3'd4,
        TIPO_OTHER  = 3'd7
    } tipo_e;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0101;

    localparam logic [3:0] EST_IF  = 4'd0;
    localparam logic [3:0] EST_ID  = 4'd1;
    localparam logic [3:0] EST_EX  = 4'd2;
    localparam logic [3:0] EST_MEM = 4'd3;
    localparam logic [3:0] EST_WB  = 4'd4;
    localparam logic [3:0] EST_FIM = 4'd5;

    function automatic logic [31:0] sext12(input logic [11:0] imm);
        return {{20{imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/riscv_decode_alu_alu_core.sv
// Purely combinational ALU datapath: add, sub, xor and logical right shift.
module riscv_alu_core
    import riscv_decode_alu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  alucontrol,
    output logic [31:0] y
);

    always_comb begin
        y = 32'd0;
        case (alucontrol)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_XOR: y = a ^ b;
            ALU_SRL: y = a >> b[4:0];
            default: y = 32'd0;
        endcase
    end

endmodule

// File: rtl/riscv_decode_alu.sv
// RV32I decode and execute capture stage, gated by the external phase value:
// decode fields latch in the ID phase, ALU result/zero/branch-taken in the EX phase.
module riscv_decode_alu
    import riscv_decode_alu_pkg::*;
#(
    parameter logic [3:0] ST_ID = EST_ID,
    parameter logic [3:0] ST_EX = EST_EX
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  estado,
    input  logic [31:0] instrucao,
    input  logic [31:0] readdata1R,
    input  logic [31:0] readdata2R,
    input  logic        alusrc,
    input  logic [3:0]  alucontrol,
    input  logic        branch,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [11:0] immediate,
    output logic [2:0]  tipo,
    output logic        negativo,
    output logic        aluresult1,
    output logic [31:0] aluresult2,
    output logic        pcsrc
);

    tipo_e       tipo_next;
    logic [11:0] imm_next;
    logic        neg_next;
    logic [31:0] operand_b;
    logic [31:0] alu_y;
    logic        alu_zero;

    always_comb begin
        tipo_next = TIPO_OTHER;
        imm_next  = 12'd0;
        neg_next  = 1'b0;
        case (instrucao[6:0])
            OP_R:      tipo_next = TIPO_R;
            OP_LOAD: begin
                tipo_next = TIPO_LOAD;
                imm_next  = instrucao[31:20];
                neg_next  = instrucao[31];
            end
            OP_IARITH: begin
                tipo_next = TIPO_IARITH;
                imm_next  = instrucao[31:20];
                neg_next  = instrucao[31];
            end
            OP_STORE: begin
                tipo_next = TIPO_STORE;
                imm_next  = {instrucao[31:25], instrucao[11:7]};
                neg_next  = instrucao[31];
            end
            // Branch offset is kept in halfword units (bit 0 dropped).
            OP_BRANCH: begin
                tipo_next = TIPO_BRANCH;
                imm_next  = {instrucao[31], instrucao[7], instrucao[30:25], instrucao[11:8]};
                neg_next  = instrucao[31];
            end
            default: tipo_next = TIPO_OTHER;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode    <= '0;
            rd        <= '0;
            rs1       <= '0;
            rs2       <= '0;
            funct3    <= '0;
            funct7    <= '0;
            immediate <= '0;
            tipo      <= '0;
            negativo  <= 1'b0;
        end else if (estado == ST_ID) begin
            opcode    <= instrucao[6:0];
            rd        <= instrucao[11:7];
            rs1       <= instrucao[19:15];
            rs2       <= instrucao[24:20];
            funct3    <= instrucao[14:12];
            funct7    <= instrucao[31:25];
            immediate <= imm_next;
            tipo      <= tipo_next;
            negativo  <= neg_next;
        end
    end

    // Operand B uses the immediate captured in ID, not the live instruction bus.
    assign operand_b = alusrc ? sext12(immediate) : readdata2R;

    riscv_alu_core u_alu_core (
        .a          (readdata1R),
        .b          (operand_b),
        .alucontrol (alucontrol),
        .y          (alu_y)
    );

    assign alu_zero = (alu_y == 32'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aluresult2 <= '0;
            aluresult1 <= 1'b0;
            pcsrc      <= 1'b0;
        end else if (estado == ST_EX) begin
            aluresult2 <= alu_y;
            aluresult1 <= alu_zero;
            pcsrc      <= branch & alu_zero;
        end
    end

endmodule

// File: tb/tb_riscv_decode_alu.sv
// Self-checking bench: table of ID+EX vectors through a scoreboard queue, plus
// hand sequences for hold, EX-only update and asynchronous reset.
module tb_riscv_decode_alu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  estado;
    logic [31:0] instrucao, readdata1R, readdata2R;
    logic        alusrc, branch;
    logic [3:0]  alucontrol;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3, tipo;
    logic [11:0] immediate;
    logic        negativo, aluresult1, pcsrc;
    logic [31:0] aluresult2;

    int n_pass = 0;
    int n_total = 0;

    localparam logic [3:0] S_ID = 4'b0001;
    localparam logic [3:0] S_EX = 4'b0010;
    localparam logic [3:0] S_IDLE = 4'b0011;

    always #5 clk = ~clk;

    riscv_decode_alu dut (
        .clk(clk), .rst_n(rst_n), .estado(estado), .instrucao(instrucao),
        .readdata1R(readdata1R), .readdata2R(readdata2R), .alusrc(alusrc),
        .alucontrol(alucontrol), .branch(branch), .opcode(opcode), .rd(rd),
        .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
        .immediate(immediate), .tipo(tipo), .negativo(negativo),
        .aluresult1(aluresult1), .aluresult2(aluresult2), .pcsrc(pcsrc)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        src;
        logic [3:0]  ctl;
        logic        br;
        logic [2:0]  e_tipo;
        logic [11:0] e_imm;
        logic        e_neg;
        logic [31:0] e_res;
        logic        e_zero;
        logic        e_pc;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  e_tipo;
        logic [11:0] e_imm;
        logic        e_neg;
        logic [31:0] e_res;
        logic        e_zero;
        logic        e_pc;
    } exp_t;

    vec_t vecs[11];
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " opcode"}, 32'(opcode), 32'd0);
        chk({tag, " rd"}, 32'(rd), 32'd0);
        chk({tag, " rs1"}, 32'(rs1), 32'd0);
        chk({tag, " rs2"}, 32'(rs2), 32'd0);
        chk({tag, " funct3"}, 32'(funct3), 32'd0);
        chk({tag, " funct7"}, 32'(funct7), 32'd0);
        chk({tag, " immediate"}, 32'(immediate), 32'd0);
        chk({tag, " tipo"}, 32'(tipo), 32'd0);
        chk({tag, " negativo"}, 32'(negativo), 32'd0);
        chk({tag, " aluresult1"}, 32'(aluresult1), 32'd0);
        chk({tag, " aluresult2"}, aluresult2, 32'd0);
        chk({tag, " pcsrc"}, 32'(pcsrc), 32'd0);
    endtask

    // ID edge with the vector's instruction, then EX edge with the bus scrambled.
    task automatic drive_vec(input vec_t v);
        exp_t e;
        estado = S_ID;
        instrucao = v.instr;
        @(posedge clk);
        @(negedge clk);
        estado = S_EX;
        instrucao = 32'hFFFF_FFFF;
        readdata1R = v.rd1;
        readdata2R = v.rd2;
        alusrc = v.src;
        alucontrol = v.ctl;
        branch = v.br;
        e = '{v.instr, v.e_tipo, v.e_imm, v.e_neg, v.e_res, v.e_zero, v.e_pc};
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        estado = S_IDLE;
    endtask

    task automatic check_sb(input string tag);
        exp_t e;
        logic [31:0] ins;
        if (sb.size() == 0) begin
            chk({tag, " scoreboard empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        ins = e.instr;
        chk({tag, " opcode"}, 32'(opcode), 32'(ins[6:0]));
        chk({tag, " rd"}, 32'(rd), 32'(ins[11:7]));
        chk({tag, " rs1"}, 32'(rs1), 32'(ins[19:15]));
        chk({tag, " rs2"}, 32'(rs2), 32'(ins[24:20]));
        chk({tag, " funct3"}, 32'(funct3), 32'(ins[14:12]));
        chk({tag, " funct7"}, 32'(funct7), 32'(ins[31:25]));
        chk({tag, " tipo"}, 32'(tipo), 32'(e.e_tipo));
        chk({tag, " immediate"}, 32'(immediate), 32'(e.e_imm));
        chk({tag, " negativo"}, 32'(negativo), 32'(e.e_neg));
        chk({tag, " aluresult2"}, aluresult2, e.e_res);
        chk({tag, " aluresult1"}, 32'(aluresult1), 32'(e.e_zero));
        chk({tag, " pcsrc"}, 32'(pcsrc), 32'(e.e_pc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{32'hFFD00293, 32'd0,          32'd0,          1'b1, 4'b0010, 1'b0, 3'd4, 12'hFFD, 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0};
        vecs[1]  = '{32'hFE208EE3, 32'd10,         32'd10,         1'b0, 4'b0110, 1'b1, 3'd3, 12'hFFE, 1'b1, 32'd0,         1'b1, 1'b1};
        vecs[2]  = '{32'h0020C1B3, 32'h0000_F0F0,  32'h0000_0FF0,  1'b0, 4'b0011, 1'b0, 3'd0, 12'h000, 1'b0, 32'h0000_FF00,  1'b0, 1'b0};
        vecs[3]  = '{32'h0020D1B3, 32'h8000_0000,  32'h0000_0024,  1'b0, 4'b0101, 1'b0, 3'd0, 12'h000, 1'b0, 32'h0800_0000,  1'b0, 1'b0};
        vecs[4]  = '{32'h0080A303, 32'h0000_0100,  32'd0,          1'b1, 4'b0010, 1'b0, 3'd1, 12'h008, 1'b0, 32'h0000_0108,  1'b0, 1'b0};
        vecs[5]  = '{32'hFE20AC23, 32'h0000_0100,  32'd0,          1'b1, 4'b0010, 1'b0, 3'd2, 12'hFF8, 1'b1, 32'h0000_00F8,  1'b0, 1'b0};
        vecs[6]  = '{32'h800000B7, 32'd5,          32'd7,          1'b1, 4'b1111, 1'b1, 3'd7, 12'h000, 1'b0, 32'd0,         1'b1, 1'b1};
        vecs[7]  = '{32'h40208033, 32'd0,          32'd1,          1'b0, 4'b0110, 1'b1, 3'd0, 12'h000, 1'b0, 32'hFFFF_FFFF,  1'b0, 1'b0};
        vecs[8]  = '{32'h002081B3, 32'hFFFF_FFFF,  32'd1,          1'b0, 4'b0010, 1'b0, 3'd0, 12'h000, 1'b0, 32'd0,         1'b1, 1'b0};
        vecs[9]  = '{32'h7FF00093, 32'd1,          32'd0,          1'b1, 4'b0010, 1'b0, 3'd4, 12'h7FF, 1'b0, 32'h0000_0800,  1'b0, 1'b0};
        vecs[10] = '{32'h0020D1B3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 4'b0101, 1'b0, 3'd0, 12'h000, 1'b0, 32'h0000_0001,  1'b0, 1'b0};

        rst_n = 1'b0;
        estado = S_IDLE;
        instrucao = 32'hFFD00293;
        readdata1R = 32'h1234_5678;
        readdata2R = 32'h1;
        alusrc = 1'b0;
        alucontrol = 4'b0010;
        branch = 1'b1;
        #1;
        chk_all_zero("reset");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            drive_vec(vecs[i]);
            check_sb($sformatf("vec%0d", i));
        end

        // Idle phase: nothing moves even with every input changing.
        drive_vec(vecs[1]);
        check_sb("beq");
        estado = S_IDLE;
        instrucao = 32'h0020C1B3;
        readdata1R = 32'h5;
        readdata2R = 32'h3;
        alucontrol = 4'b0110;
        branch = 1'b1;
        alusrc = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("hold tipo", 32'(tipo), 32'd3);
        chk("hold immediate", 32'(immediate), 32'hFFE);
        chk("hold negativo", 32'(negativo), 32'd1);
        chk("hold aluresult2", aluresult2, 32'd0);
        chk("hold aluresult1", 32'(aluresult1), 32'd1);
        chk("hold pcsrc", 32'(pcsrc), 32'd1);

        // EX edge alone: ALU outputs move, decode stays from the beq.
        estado = S_EX;
        @(posedge clk);
        @(negedge clk);
        estado = S_IDLE;
        chk("exonly aluresult2", aluresult2, 32'd2);
        chk("exonly aluresult1", 32'(aluresult1), 32'd0);
        chk("exonly pcsrc", 32'(pcsrc), 32'd0);
        chk("exonly tipo", 32'(tipo), 32'd3);
        chk("exonly opcode", 32'(opcode), 32'h63);
        chk("exonly immediate", 32'(immediate), 32'hFFE);

        // Async reset pulse between edges after a taken beq.
        drive_vec(vecs[1]);
        check_sb("beq2");
        #1 rst_n = 1'b0;
        #1;
        chk("arst pcsrc", 32'(pcsrc), 32'd0);
        chk("arst aluresult1", 32'(aluresult1), 32'd0);
        chk("arst aluresult2", aluresult2, 32'd0);
        chk("arst immediate", 32'(immediate), 32'd0);
        chk("arst tipo", 32'(tipo), 32'd0);
        rst_n = 1'b1;

        // Reset after ID discards the captured immediate before EX uses it.
        @(negedge clk);
        estado = S_ID;
        instrucao = 32'hFFD00293;
        @(posedge clk);
        @(negedge clk);
        chk("mid id immediate", 32'(immediate), 32'hFFD);
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        estado = S_EX;
        instrucao = 32'h0;
        readdata1R = 32'h0000_0040;
        alusrc = 1'b1;
        alucontrol = 4'b0010;
        branch = 1'b0;
        @(posedge clk);
        @(negedge clk);
        estado = S_IDLE;
        chk("mid ex aluresult2", aluresult2, 32'h0000_0040);
        chk("mid ex immediate", 32'(immediate), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
